// File: rtl/block_mover.sv
// Per-frame x/y origin controller for a rectangular block sprite.
// Moves the block during vertical blanking and bounces it off the screen edges.
module block_mover #(
  parameter int WIDTH    = 256,
  parameter int HEIGHT   = 256,
  parameter int SCREEN_W = 1280,
  parameter int SCREEN_H = 720,
  parameter int X_START  = 512,
  parameter int Y_START  = 232
) (
  input  logic        clk_pixel,
  input  logic        rst_in,
  input  logic        new_frame_in,
  input  logic        run_in,
  input  logic [3:0]  dx_in,
  input  logic [3:0]  dy_in,
  output logic [10:0] x_out,
  output logic [9:0]  y_out,
  output logic        dir_x_out,
  output logic        dir_y_out,
  output logic        bounce_x_out,
  output logic        bounce_y_out
);

  localparam logic [11:0] X_MAX  = 12'(SCREEN_W - WIDTH);
  localparam logic [10:0] Y_MAX  = 11'(SCREEN_H - HEIGHT);
  localparam logic [10:0] X_INIT = 11'(X_START);
  localparam logic [9:0]  Y_INIT = 10'(Y_START);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    CALC   = 2'd2,
    COMMIT = 2'd3
  } state_t;

  state_t      state_q;
  logic [3:0]  dx_q, dy_q;
  logic [10:0] x_q;
  logic [9:0]  y_q;
  logic        dir_x_q, dir_y_q;
  logic        bounce_x_q, bounce_y_q;

  logic [11:0] x_ext, x_sum, dx_ext;
  logic [10:0] y_ext, y_sum, dy_ext;
  logic [10:0] x_d;
  logic [9:0]  y_d;
  logic        dir_x_d, dir_y_d;
  logic        flip_x_d, flip_y_d;

  assign x_ext  = {1'b0, x_q};
  assign dx_ext = {8'b0, dx_q};
  assign x_sum  = x_ext + dx_ext;
  assign y_ext  = {1'b0, y_q};
  assign dy_ext = {7'b0, dy_q};
  assign y_sum  = y_ext + dy_ext;

  // Next x position/direction; a zero speed never moves or flips, even on an edge.
  always_comb begin
    x_d      = x_q;
    dir_x_d  = dir_x_q;
    flip_x_d = 1'b0;
    if (dx_q == 4'd0) begin
      x_d = x_q;
    end else if (!dir_x_q) begin
      if (x_sum >= X_MAX) begin
        x_d      = X_MAX[10:0];
        dir_x_d  = 1'b1;
        flip_x_d = 1'b1;
      end else begin
        x_d = x_sum[10:0];
      end
    end else begin
      if (x_ext <= dx_ext) begin
        x_d      = 11'd0;
        dir_x_d  = 1'b0;
        flip_x_d = 1'b1;
      end else begin
        x_d = x_q - {7'b0, dx_q};
      end
    end
  end

  // Next y position/direction, same rules as x.
  always_comb begin
    y_d      = y_q;
    dir_y_d  = dir_y_q;
    flip_y_d = 1'b0;
    if (dy_q == 4'd0) begin
      y_d = y_q;
    end else if (!dir_y_q) begin
      if (y_sum >= Y_MAX) begin
        y_d      = Y_MAX[9:0];
        dir_y_d  = 1'b1;
        flip_y_d = 1'b1;
      end else begin
        y_d = y_sum[9:0];
      end
    end else begin
      if (y_ext <= dy_ext) begin
        y_d      = 10'd0;
        dir_y_d  = 1'b0;
        flip_y_d = 1'b1;
      end else begin
        y_d = y_q - {6'b0, dy_q};
      end
    end
  end

  // Frame-update FSM; results land at the end of CALC so they are visible during COMMIT.
  always_ff @(posedge clk_pixel) begin
    if (rst_in) begin
      state_q    <= IDLE;
      dx_q       <= 4'd0;
      dy_q       <= 4'd0;
      x_q        <= X_INIT;
      y_q        <= Y_INIT;
      dir_x_q    <= 1'b0;
      dir_y_q    <= 1'b0;
      bounce_x_q <= 1'b0;
      bounce_y_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (new_frame_in && run_in) begin
            dx_q    <= dx_in;
            dy_q    <= dy_in;
            state_q <= CALC;
          end else begin
            state_q <= IDLE;
          end
        end
        RUN: begin
          if (new_frame_in) begin
            dx_q    <= dx_in;
            dy_q    <= dy_in;
            state_q <= CALC;
          end else begin
            state_q <= RUN;
          end
        end
        CALC: begin
          x_q        <= x_d;
          y_q        <= y_d;
          dir_x_q    <= dir_x_d;
          dir_y_q    <= dir_y_d;
          bounce_x_q <= flip_x_d;
          bounce_y_q <= flip_y_d;
          state_q    <= COMMIT;
        end
        COMMIT: begin
          bounce_x_q <= 1'b0;
          bounce_y_q <= 1'b0;
          state_q    <= run_in ? RUN : IDLE;
        end
        default: begin
          bounce_x_q <= 1'b0;
          bounce_y_q <= 1'b0;
          state_q    <= IDLE;
        end
      endcase
    end
  end

  assign x_out        = x_q;
  assign y_out        = y_q;
  assign dir_x_out    = dir_x_q;
  assign dir_y_out    = dir_y_q;
  assign bounce_x_out = bounce_x_q;
  assign bounce_y_out = bounce_y_q;

endmodule

// File: tb/tb_block_mover.sv
// Self-checking bench for block_mover: directed edge cases plus random stimulus
// against a per-frame behavioural position model.
`timescale 1ns/1ps
module tb_block_mover;

  localparam int X_MAX = 1024;
  localparam int Y_MAX = 464;

  logic        clk_pixel = 1'b0;
  logic        rst_in = 1'b1;
  logic        new_frame_in = 1'b0;
  logic        run_in = 1'b0;
  logic [3:0]  dx_in = 4'd0;
  logic [3:0]  dy_in = 4'd0;
  logic [10:0] x_out;
  logic [9:0]  y_out;
  logic        dir_x_out, dir_y_out, bounce_x_out, bounce_y_out;

  int n_checks = 0;
  int n_fail   = 0;

  // Model: position, direction, pending-update countdown and run mode.
  int mx, my, mdx, mdy, pend;
  bit mdirx, mdiry, mbx, mby, mrun;

  block_mover dut (
    .clk_pixel(clk_pixel), .rst_in(rst_in), .new_frame_in(new_frame_in),
    .run_in(run_in), .dx_in(dx_in), .dy_in(dy_in),
    .x_out(x_out), .y_out(y_out), .dir_x_out(dir_x_out), .dir_y_out(dir_y_out),
    .bounce_x_out(bounce_x_out), .bounce_y_out(bounce_y_out)
  );

  always #5 clk_pixel = ~clk_pixel;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // One axis of the frame step.
  task automatic move(inout int p, inout bit dir, output bit b, input int d, input int pmax);
    b = 1'b0;
    if (d != 0) begin
      if (!dir) begin
        if (p + d >= pmax) begin p = pmax; dir = 1'b1; b = 1'b1; end
        else p = p + d;
      end else begin
        if (p <= d) begin p = 0; dir = 1'b0; b = 1'b1; end
        else p = p - d;
      end
    end
  endtask

  // Advance one clock: update the model from the inputs seen at the edge, then compare.
  task automatic tick();
    @(posedge clk_pixel);
    if (rst_in) begin
      mx = 512; my = 232; mdirx = 0; mdiry = 0; mbx = 0; mby = 0;
      pend = 0; mrun = 0;
    end else begin
      mbx = 0; mby = 0;
      if (pend == 2) begin
        move(mx, mdirx, mbx, mdx, X_MAX);
        move(my, mdiry, mby, mdy, Y_MAX);
        pend = 1;
      end else if (pend == 1) begin
        mrun = run_in;
        pend = 0;
      end else if (new_frame_in && (run_in || mrun)) begin
        mdx = int'(dx_in); mdy = int'(dy_in); pend = 2;
      end
    end
    #1;
    chk("x_model", int'(x_out), mx);
    chk("y_model", int'(y_out), my);
    chk("dirx_model", int'(dir_x_out), int'(mdirx));
    chk("diry_model", int'(dir_y_out), int'(mdiry));
    chk("bx_model", int'(bounce_x_out), int'(mbx));
    chk("by_model", int'(bounce_y_out), int'(mby));
  endtask

  // Leaves the DUT in its COMMIT cycle with new outputs and bounce pulses visible.
  task automatic frame(input int dx, input int dy);
    new_frame_in = 1'b0;
    tick();
    new_frame_in = 1'b1; dx_in = 4'(dx); dy_in = 4'(dy);
    tick();
    new_frame_in = 1'b0;
    tick();
  endtask

  initial begin
    int guard;
    rst_in = 1'b1;
    tick(); tick();
    rst_in = 1'b0;
    chk("reset_x", int'(x_out), 512);
    chk("reset_y", int'(y_out), 232);
    chk("reset_dirs", int'({dir_x_out, dir_y_out}), 0);
    chk("reset_bounce", int'({bounce_x_out, bounce_y_out}), 0);

    // Idle hold
    run_in = 1'b0;
    frame(3, 2); tick();
    chk("idle_x", int'(x_out), 512);
    chk("idle_y", int'(y_out), 232);

    // Basic move with latency
    run_in = 1'b1;
    tick();
    new_frame_in = 1'b1; dx_in = 4'd3; dy_in = 4'd2;
    tick();
    new_frame_in = 1'b0; dx_in = 4'd9;
    chk("t1_x", int'(x_out), 512);
    chk("t1_y", int'(y_out), 232);
    tick();
    chk("t2_x", int'(x_out), 515);
    chk("t2_y", int'(y_out), 234);

    // Walk to 1022, then bounce off the right edge
    guard = 0;
    while (mx + 15 < 1022 && guard < 200) begin frame(15, 0); guard++; end
    if (mx < 1022) frame(1022 - mx, 0);
    chk("pre_right_x", int'(x_out), 1022);
    frame(5, 0);
    chk("right_x", int'(x_out), 1024);
    chk("right_dir", int'(dir_x_out), 1);
    chk("right_bounce", int'(bounce_x_out), 1);
    tick();
    chk("right_bounce_end", int'(bounce_x_out), 0);
    frame(5, 0);
    chk("after_right_x", int'(x_out), 1019);

    // Bring x to 1 moving left and y to 1 moving up, then a double bounce
    guard = 0;
    while (mx > 16 && guard < 200) begin frame(15, 0); guard++; end
    if (mx > 1) frame(mx - 1, 0);
    guard = 0;
    while (!mdiry && guard < 200) begin frame(0, 15); guard++; end
    guard = 0;
    while (my > 16 && guard < 200) begin frame(0, 15); guard++; end
    if (my > 1) frame(0, my - 1);
    chk("pre_corner_x", int'(x_out), 1);
    chk("pre_corner_y", int'(y_out), 1);
    chk("pre_corner_dirs", int'({dir_x_out, dir_y_out}), 3);
    frame(4, 4);
    chk("corner_x", int'(x_out), 0);
    chk("corner_y", int'(y_out), 0);
    chk("corner_dirs", int'({dir_x_out, dir_y_out}), 0);
    chk("corner_bounces", int'({bounce_x_out, bounce_y_out}), 3);

    // Zero speed on an edge
    frame(0, 0);
    chk("zero_x", int'(x_out), 0);
    chk("zero_bounce", int'({bounce_x_out, bounce_y_out}), 0);

    // Back-to-back pulses give one update
    tick();
    new_frame_in = 1'b1; dx_in = 4'd1; dy_in = 4'd0;
    tick(); tick();
    new_frame_in = 1'b0;
    tick(); tick(); tick();
    chk("double_pulse_x", int'(x_out), 1);

    // Reset during CALC, then confirm IDLE ignores frames without run_in
    tick();
    new_frame_in = 1'b1; dx_in = 4'd7; dy_in = 4'd7;
    tick();
    new_frame_in = 1'b0; rst_in = 1'b1;
    tick();
    rst_in = 1'b0;
    chk("rst_calc_x", int'(x_out), 512);
    chk("rst_calc_y", int'(y_out), 232);
    chk("rst_calc_dirs", int'({dir_x_out, dir_y_out}), 0);
    chk("rst_calc_bounce", int'({bounce_x_out, bounce_y_out}), 0);
    run_in = 1'b0;
    frame(5, 5); tick();
    chk("rst_idle_x", int'(x_out), 512);

    // Random traffic
    for (int i = 0; i < 4000; i++) begin
      run_in       = ($urandom_range(0, 3) != 0);
      new_frame_in = ($urandom_range(0, 5) == 0);
      dx_in        = 4'($urandom_range(0, 15));
      dy_in        = 4'($urandom_range(0, 15));
      rst_in       = ($urandom_range(0, 599) == 0);
      tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
